alu_pipe: RTL

//  Two-stage pipelined x86 integer ALU with selectable operand size (8/16/32) and EFLAGS generation.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_pipe_if.sv | 31 +++
 rtl/alu_core_comb.sv | 171 +++++++++++++++++
 rtl/alu_pipe.sv | 106 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op/size encodings and EFLAGS bit positions for the pipelined ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_OR   = 4'd1,
    OP_NOT  = 4'd2,
    OP_DAA  = 4'd3,
    OP_AND  = 4'd4,
    OP_CLD  = 4'd5,
    OP_SUB  = 4'd6,
    OP_STD  = 4'd7,
    OP_ADC  = 4'd8,
    OP_SBB  = 4'd9,
    OP_XOR  = 4'd10,
    OP_CMP  = 4'd11,
    OP_INC  = 4'd12,
    OP_DEC  = 4'd13,
    OP_NEG  = 4'd14,
    OP_PASS = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    SZ_8   = 2'd0,
    SZ_16  = 2'd1,
    SZ_32  = 2'd2,
    SZ_RSV = 2'd3
  } size_e;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_AF = 4;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;
  localparam int FLAG_DF = 10;
  localparam int FLAG_OF = 11;

  localparam logic [31:0] EFLAGS_RESET = 32'h0000_0002;

endpackage

// File: rtl/alu_pipe_if.sv
// Operation-in / result-out handshake bundle of the ALU; slave is the ALU, master the producer/consumer side.
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FLAGS_W = 32
);

  logic               in_valid;
  logic               in_ready;
  alu_op_e            op;
  size_e              size;
  logic [DATA_W-1:0]  a;
  logic [DATA_W-1:0]  b;
  logic [FLAGS_W-1:0] flags_in;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  alu_out;
  logic [FLAGS_W-1:0] flags_out;

  modport master (
    output in_valid, op, size, a, b, flags_in, out_ready,
    input  in_ready, out_valid, alu_out, flags_out
  );

  modport slave (
    input  in_valid, op, size, a, b, flags_in, out_ready,
    output in_ready, out_valid, alu_out, flags_out
  );

endinterface

// File: rtl/alu_core_comb.sv
// Combinational x86 ALU datapath: {op,size,a,b,flags} -> {merged result, updated EFLAGS}.
// No state, zero latency; backpressure is handled entirely by the enclosing pipeline.
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FLAGS_W = 32
) (
  input  alu_op_e            op_i,
  input  size_e              size_i,
  input  logic [DATA_W-1:0]  a_i,
  input  logic [DATA_W-1:0]  b_i,
  input  logic [FLAGS_W-1:0] flags_i,
  output logic [DATA_W-1:0]  res_o,
  output logic [FLAGS_W-1:0] flags_o
);

  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] x, y, y_eff, r, merged;
  logic [DATA_W:0]   xe, ye, sum;
  logic              is_sub, cin, cin_eff;
  logic              c_out, c_msb, c_af;
  logic              cf, of, af, sf, zf, pf;
  logic [7:0]        al, daa_al;
  logic              daa_lo, daa_hi;
  logic [FLAGS_W-1:0] f_arith, f_logic, f_daa;

  always_comb begin
    case (size_i)
      SZ_8:    mask = DATA_W'(32'h0000_00FF);
      SZ_16:   mask = DATA_W'(32'h0000_FFFF);
      default: mask = DATA_W'(32'hFFFF_FFFF);
    endcase
  end

  always_comb begin
    x      = a_i;
    y      = b_i;
    is_sub = 1'b0;
    cin    = 1'b0;
    case (op_i)
      OP_ADC:         cin = flags_i[FLAG_CF];
      OP_SUB, OP_CMP: is_sub = 1'b1;
      OP_SBB: begin
        is_sub = 1'b1;
        cin    = flags_i[FLAG_CF];
      end
      OP_INC:         y = DATA_W'(1);
      OP_DEC: begin
        is_sub = 1'b1;
        y      = DATA_W'(1);
      end
      OP_NEG: begin
        is_sub = 1'b1;
        x      = '0;
        y      = a_i;
      end
      default: ;
    endcase
  end

  // Subtraction runs as x + ~y + !borrow; carry outputs are inverted back to borrows.
  assign y_eff   = is_sub ? ~y : y;
  assign cin_eff = is_sub ? ~cin : cin;
  assign xe      = {1'b0, x};
  assign ye      = {1'b0, y_eff};
  assign sum     = xe + ye + {{DATA_W{1'b0}}, cin_eff};

  always_comb begin
    case (size_i)
      SZ_8: begin
        c_out = sum[8] ^ xe[8] ^ ye[8];
        c_msb = sum[7] ^ xe[7] ^ ye[7];
        sf    = r[7];
      end
      SZ_16: begin
        c_out = sum[16] ^ xe[16] ^ ye[16];
        c_msb = sum[15] ^ xe[15] ^ ye[15];
        sf    = r[15];
      end
      default: begin
        c_out = sum[32] ^ xe[32] ^ ye[32];
        c_msb = sum[31] ^ xe[31] ^ ye[31];
        sf    = r[31];
      end
    endcase
  end

  assign c_af = sum[4] ^ xe[4] ^ ye[4];
  assign cf   = c_out ^ is_sub;
  assign af   = c_af ^ is_sub;
  assign of   = c_out ^ c_msb;

  always_comb begin
    case (op_i)
      OP_OR:   r = a_i | b_i;
      OP_AND:  r = a_i & b_i;
      OP_XOR:  r = a_i ^ b_i;
      OP_NOT:  r = ~a_i;
      default: r = sum[DATA_W-1:0];
    endcase
  end

  assign merged = (a_i & ~mask) | (r & mask);
  assign zf     = ((r & mask) == '0);
  assign pf     = ~^r[7:0];

  // DAA works on the old AL with the old CF/AF, independent of size.
  assign al     = a_i[7:0];
  assign daa_lo = (al[3:0] > 4'd9) || flags_i[FLAG_AF];
  assign daa_hi = (al > 8'h99) || flags_i[FLAG_CF];
  assign daa_al = al + (daa_lo ? 8'h06 : 8'h00) + (daa_hi ? 8'h60 : 8'h00);

  always_comb begin
    f_arith          = flags_i;
    f_arith[FLAG_CF] = cf;
    f_arith[FLAG_PF] = pf;
    f_arith[FLAG_AF] = af;
    f_arith[FLAG_ZF] = zf;
    f_arith[FLAG_SF] = sf;
    f_arith[FLAG_OF] = of;

    f_logic          = flags_i;
    f_logic[FLAG_CF] = 1'b0;
    f_logic[FLAG_PF] = pf;
    f_logic[FLAG_AF] = 1'b0;
    f_logic[FLAG_ZF] = zf;
    f_logic[FLAG_SF] = sf;
    f_logic[FLAG_OF] = 1'b0;

    f_daa            = flags_i;
    f_daa[FLAG_CF]   = daa_hi;
    f_daa[FLAG_PF]   = ~^daa_al;
    f_daa[FLAG_AF]   = daa_lo;
    f_daa[FLAG_ZF]   = (daa_al == 8'h00);
    f_daa[FLAG_SF]   = daa_al[7];
    f_daa[FLAG_OF]   = 1'b0;
  end

  always_comb begin
    res_o   = merged;
    flags_o = flags_i;
    case (op_i)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_NEG: flags_o = f_arith;
      OP_CMP: begin
        res_o   = a_i;
        flags_o = f_arith;
      end
      OP_INC, OP_DEC: begin
        flags_o          = f_arith;
        flags_o[FLAG_CF] = flags_i[FLAG_CF];
      end
      OP_OR, OP_AND, OP_XOR: flags_o = f_logic;
      OP_DAA: begin
        res_o   = {a_i[DATA_W-1:8], daa_al};
        flags_o = f_daa;
      end
      OP_CLD: begin
        res_o            = a_i;
        flags_o[FLAG_DF] = 1'b0;
      end
      OP_STD: begin
        res_o            = a_i;
        flags_o[FLAG_DF] = 1'b1;
      end
      OP_PASS: res_o = a_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline: 2 cycles accept->out_valid, 1 op/cycle; out_ready low freezes S2
// and S1 holds when full, dropping in_ready.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FLAGS_W = 32
) (
  input logic       CLK,
  input logic       RST,
  alu_pipe_if.slave bus
);

  logic               s1_vld_q, s1_vld_d;
  alu_op_e            s1_op_q, s1_op_d;
  size_e              s1_size_q, s1_size_d;
  logic [DATA_W-1:0]  s1_a_q, s1_a_d;
  logic [DATA_W-1:0]  s1_b_q, s1_b_d;
  logic [FLAGS_W-1:0] s1_flags_q, s1_flags_d;

  logic               s2_vld_q, s2_vld_d;
  logic [DATA_W-1:0]  s2_res_q, s2_res_d;
  logic [FLAGS_W-1:0] s2_flags_q, s2_flags_d;

  logic               adv, accept;
  logic [DATA_W-1:0]  core_res;
  logic [FLAGS_W-1:0] core_flags;

  assign adv          = !s2_vld_q || bus.out_ready;
  assign bus.in_ready = !RST && (!s1_vld_q || adv);
  assign accept       = bus.in_valid && bus.in_ready;

  alu_core_comb #(
    .DATA_W  (DATA_W),
    .FLAGS_W (FLAGS_W)
  ) u_core (
    .op_i    (s1_op_q),
    .size_i  (s1_size_q),
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .flags_i (s1_flags_q),
    .res_o   (core_res),
    .flags_o (core_flags)
  );

  always_comb begin
    s1_op_d    = s1_op_q;
    s1_size_d  = s1_size_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_flags_d = s1_flags_q;
    if (accept) begin
      s1_op_d    = bus.op;
      s1_size_d  = bus.size;
      s1_a_d     = bus.a;
      s1_b_d     = bus.b;
      s1_flags_d = bus.flags_in;
    end
  end

  // S2 drain and S1 refill may happen in the same cycle, so accept overrides the clear.
  always_comb begin
    s1_vld_d   = s1_vld_q;
    s2_vld_d   = s2_vld_q;
    s2_res_d   = s2_res_q;
    s2_flags_d = s2_flags_q;
    if (adv) begin
      s2_vld_d = s1_vld_q;
      s1_vld_d = 1'b0;
      if (s1_vld_q) begin
        s2_res_d   = core_res;
        s2_flags_d = core_flags;
      end
    end
    if (accept) begin
      s1_vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= FLAGS_W'(EFLAGS_RESET);
    end else begin
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  always_ff @(posedge CLK) begin
    s1_op_q    <= s1_op_d;
    s1_size_q  <= s1_size_d;
    s1_a_q     <= s1_a_d;
    s1_b_q     <= s1_b_d;
    s1_flags_q <= s1_flags_d;
  end

  assign bus.out_valid = s2_vld_q;
  assign bus.alu_out   = s2_res_q;
  assign bus.flags_out = s2_flags_q;

endmodule
